mem_ctrl: RTL and testbench

// - Bus-side memory controller that sits between the main bus and the memory array, and drives the array's memArray_if signals.
// - Decodes a page-select address cycle, then runs a 4-word burst.
//   - Read: array data is returned onto the bus.
//   - Write: bus data is written into the array.
// - One instance serves one page; several instances can share a bus.

---
 rtl/mem_ctrl.sv | 128 ++++++++++++
 tb/tb_mem_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Single-page memory controller: page-select address cycle followed by a
// critical-word-first burst. Optional burst counters under MEMCTRL_STATS_EN.
module mem_ctrl #(
  parameter  int BUSWIDTH  = 16,
  parameter  int MEMSIZE   = 256,
  parameter  int PAGE      = 'h2,
  parameter  int BURSTLEN  = 4,
  localparam int ADDRWIDTH = $clog2(MEMSIZE)
) (
  input  logic                 clk,
  input  logic                 resetL,
  input  logic                 AddrValid,
  input  logic                 rw,
  input  logic [BUSWIDTH-1:0]  BusAddrData,
  output logic [BUSWIDTH-1:0]  BusDataOut,
  output logic                 BusDataOE,
  output logic [ADDRWIDTH-1:0] Addr,
  output logic [BUSWIDTH-1:0]  DataIn,
  input  logic [BUSWIDTH-1:0]  DataOut,
  output logic                 rdEn,
  output logic                 wrEn
`ifdef MEMCTRL_STATS_EN
  ,
  output logic [15:0]          rdBursts,
  output logic [15:0]          wrBursts
`endif
);

  localparam int PAGEWIDTH = BUSWIDTH - ADDRWIDTH;
  localparam logic [PAGEWIDTH-1:0] PAGE_BITS = PAGEWIDTH'(PAGE);
  // Low address bits that rotate inside one BURSTLEN-aligned block.
  localparam logic [ADDRWIDTH-1:0] BLK_MASK  = ADDRWIDTH'(BURSTLEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t               state;
  state_t               next_state;
  logic [ADDRWIDTH-1:0] base;
  logic [ADDRWIDTH-1:0] offset;
  logic                 hit;
  logic                 last_beat;
  logic [ADDRWIDTH-1:0] burst_addr;

  assign hit        = AddrValid && (BusAddrData[BUSWIDTH-1:ADDRWIDTH] == PAGE_BITS);
  assign last_beat  = (offset == BLK_MASK);
  assign burst_addr = (base & ~BLK_MASK) | ((base + offset) & BLK_MASK);

  always_ff @(posedge clk) begin
    if (!resetL) begin
      state  <= IDLE;
      base   <= '0;
      offset <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE) begin
        if (hit) begin
          base   <= BusAddrData[ADDRWIDTH-1:0];
          offset <= '0;
        end
      end else begin
        offset <= (offset + 1'b1) & BLK_MASK;
      end
    end
  end

  // AddrValid is only looked at in IDLE; a strobe during a burst is dropped.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (hit) begin
          next_state = rw ? RD : WR;
        end
      end
      RD, WR: begin
        if (last_beat) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    Addr       = '0;
    rdEn       = 1'b0;
    wrEn       = 1'b0;
    BusDataOE  = 1'b0;
    BusDataOut = '0;
    DataIn     = '0;
    case (state)
      RD: begin
        Addr       = burst_addr;
        rdEn       = 1'b1;
        BusDataOE  = 1'b1;
        BusDataOut = DataOut;
      end
      WR: begin
        Addr   = burst_addr;
        wrEn   = 1'b1;
        DataIn = BusAddrData;
      end
      default: ;
    endcase
  end

`ifdef MEMCTRL_STATS_EN
  // Counted only on a clean exit after the final beat; a reset edge wins.
  always_ff @(posedge clk) begin
    if (!resetL) begin
      rdBursts <= '0;
      wrBursts <= '0;
    end else begin
      if (state == RD && last_beat && rdBursts != 16'hFFFF) begin
        rdBursts <= rdBursts + 16'd1;
      end
      if (state == WR && last_beat && wrBursts != 16'hFFFF) begin
        wrBursts <= wrBursts + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl with a behavioural memory array model.
module tb_mem_ctrl;

  logic        clk;
  logic        resetL;
  logic        AddrValid;
  logic        rw;
  logic [15:0] BusAddrData;
  logic [15:0] BusDataOut;
  logic        BusDataOE;
  logic [7:0]  Addr;
  logic [15:0] DataIn;
  logic [15:0] DataOut;
  logic        rdEn;
  logic        wrEn;
`ifdef MEMCTRL_STATS_EN
  logic [15:0] rdBursts;
  logic [15:0] wrBursts;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int rd_exp   = 0;
  int wr_exp   = 0;

  logic [15:0] mem [256];
  logic [15:0] a_data [4];

  mem_ctrl dut (
    .clk        (clk),
    .resetL     (resetL),
    .AddrValid  (AddrValid),
    .rw         (rw),
    .BusAddrData(BusAddrData),
    .BusDataOut (BusDataOut),
    .BusDataOE  (BusDataOE),
    .Addr       (Addr),
    .DataIn     (DataIn),
    .DataOut    (DataOut),
    .rdEn       (rdEn),
    .wrEn       (wrEn)
`ifdef MEMCTRL_STATS_EN
    ,
    .rdBursts   (rdBursts),
    .wrBursts   (wrBursts)
`endif
  );

  // Memory array model: combinational read, write committed at posedge.
  assign DataOut = rdEn ? mem[Addr] : 16'h0000;

  always @(posedge clk) begin
    if (wrEn) mem[Addr] <= DataIn;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetL      = 1'b0;
    AddrValid   = 1'b1;
    rw          = 1'b1;
    BusAddrData = 16'h0210;
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      @(negedge clk);
      n_checks++;
      if ({rdEn, wrEn, BusDataOE} !== 3'b000) begin
        n_fail++;
        $display("[TB] FAIL reset_enables cycle %0d: got %b expected 000", c, {rdEn, wrEn, BusDataOE});
      end
      n_checks++;
      if ({Addr, BusDataOut, DataIn} !== 40'h0) begin
        n_fail++;
        $display("[TB] FAIL reset_data cycle %0d: got Addr=%h Out=%h In=%h expected all 0", c, Addr, BusDataOut, DataIn);
      end
    end
    next_cycle();
    resetL    = 1'b1;
    AddrValid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({rdEn, wrEn, BusDataOE} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL reset_release: got %b expected 000", {rdEn, wrEn, BusDataOE});
    end
`ifdef MEMCTRL_STATS_EN
    n_checks++;
    if (rdBursts !== 16'd0 || wrBursts !== 16'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_stats: got rd=%0d wr=%0d expected 0 0", rdBursts, wrBursts);
    end
`endif
  endtask

  task automatic test_write();
    next_cycle();
    AddrValid   = 1'b1;
    rw          = 1'b0;
    BusAddrData = 16'h0210;
    @(negedge clk);
    n_checks++;
    if (wrEn !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL write_t0_wrEn: got %b expected 0", wrEn);
    end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      AddrValid   = 1'b0;
      rw          = 1'b1;
      BusAddrData = a_data[i];
      @(negedge clk);
      n_checks++;
      if ({wrEn, rdEn, BusDataOE} !== 3'b100) begin
        n_fail++;
        $display("[TB] FAIL write_enables beat %0d: got %b expected 100", i, {wrEn, rdEn, BusDataOE});
      end
      n_checks++;
      if (Addr !== 8'h10 + 8'(i)) begin
        n_fail++;
        $display("[TB] FAIL write_addr beat %0d: got %h expected %h", i, Addr, 8'h10 + 8'(i));
      end
      n_checks++;
      if (DataIn !== a_data[i]) begin
        n_fail++;
        $display("[TB] FAIL write_data beat %0d: got %h expected %h", i, DataIn, a_data[i]);
      end
    end
    next_cycle();
    BusAddrData = 16'h0000;
    wr_exp++;
    @(negedge clk);
    n_checks++;
    if (wrEn !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL write_t5_wrEn: got %b expected 0", wrEn);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mem[8'h10 + i] !== a_data[i]) begin
        n_fail++;
        $display("[TB] FAIL write_array word %0d: got %h expected %h", i, mem[8'h10 + i], a_data[i]);
      end
    end
`ifdef MEMCTRL_STATS_EN
    n_checks++;
    if (wrBursts !== 16'(wr_exp) || rdBursts !== 16'(rd_exp)) begin
      n_fail++;
      $display("[TB] FAIL write_stats: got rd=%0d wr=%0d expected %0d %0d", rdBursts, wrBursts, rd_exp, wr_exp);
    end
`endif
  endtask

  task automatic test_read();
    next_cycle();
    AddrValid   = 1'b1;
    rw          = 1'b1;
    BusAddrData = 16'h0212;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      AddrValid   = 1'b0;
      rw          = 1'b0;
      BusAddrData = 16'h5555;
      @(negedge clk);
      n_checks++;
      if ({rdEn, BusDataOE, wrEn} !== 3'b110) begin
        n_fail++;
        $display("[TB] FAIL read_enables beat %0d: got %b expected 110", i, {rdEn, BusDataOE, wrEn});
      end
      n_checks++;
      if (Addr !== 8'h10 + 8'((2 + i) % 4)) begin
        n_fail++;
        $display("[TB] FAIL read_addr beat %0d: got %h expected %h", i, Addr, 8'h10 + 8'((2 + i) % 4));
      end
      n_checks++;
      if (BusDataOut !== a_data[(2 + i) % 4]) begin
        n_fail++;
        $display("[TB] FAIL read_data beat %0d: got %h expected %h", i, BusDataOut, a_data[(2 + i) % 4]);
      end
    end
    next_cycle();
    rd_exp++;
    @(negedge clk);
    n_checks++;
    if ({rdEn, BusDataOE, BusDataOut} !== 18'h0) begin
      n_fail++;
      $display("[TB] FAIL read_t5_idle: got rdEn=%b OE=%b Out=%h expected 0", rdEn, BusDataOE, BusDataOut);
    end
`ifdef MEMCTRL_STATS_EN
    n_checks++;
    if (rdBursts !== 16'(rd_exp) || wrBursts !== 16'(wr_exp)) begin
      n_fail++;
      $display("[TB] FAIL read_stats: got rd=%0d wr=%0d expected %0d %0d", rdBursts, wrBursts, rd_exp, wr_exp);
    end
`endif
  endtask

  task automatic test_page_miss();
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      AddrValid   = 1'b1;
      rw          = c[0];
      BusAddrData = 16'h0310;
      @(negedge clk);
      n_checks++;
      if ({rdEn, wrEn, BusDataOE} !== 3'b000) begin
        n_fail++;
        $display("[TB] FAIL miss_enables cycle %0d: got %b expected 000", c, {rdEn, wrEn, BusDataOE});
      end
    end
    next_cycle();
    AddrValid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({rdEn, wrEn, BusDataOE} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL miss_after: got %b expected 000", {rdEn, wrEn, BusDataOE});
    end
  endtask

  task automatic test_reset_mid_burst();
    next_cycle();
    AddrValid   = 1'b1;
    rw          = 1'b1;
    BusAddrData = 16'h0210;
    next_cycle();
    AddrValid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rdEn !== 1'b1 || Addr !== 8'h10 || BusDataOut !== a_data[0]) begin
      n_fail++;
      $display("[TB] FAIL midrst_t1: got rdEn=%b Addr=%h Out=%h expected 1 10 %h", rdEn, Addr, BusDataOut, a_data[0]);
    end
    next_cycle();
    resetL = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rdEn !== 1'b1 || BusDataOE !== 1'b1 || Addr !== 8'h11 || BusDataOut !== a_data[1]) begin
      n_fail++;
      $display("[TB] FAIL midrst_t2: got rdEn=%b OE=%b Addr=%h Out=%h expected 1 1 11 %h", rdEn, BusDataOE, Addr, BusDataOut, a_data[1]);
    end
    next_cycle();
    resetL = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({rdEn, wrEn, BusDataOE} !== 3'b000 || Addr !== 8'h00 || BusDataOut !== 16'h0) begin
      n_fail++;
      $display("[TB] FAIL midrst_t3: got en=%b Addr=%h Out=%h expected 000 00 0000", {rdEn, wrEn, BusDataOE}, Addr, BusDataOut);
    end
`ifdef MEMCTRL_STATS_EN
    n_checks++;
    if (rdBursts !== 16'd0 || wrBursts !== 16'd0) begin
      n_fail++;
      $display("[TB] FAIL midrst_stats_cleared: got rd=%0d wr=%0d expected 0 0", rdBursts, wrBursts);
    end
    rd_exp = 0;
    wr_exp = 0;
`endif
    next_cycle();
    AddrValid   = 1'b1;
    rw          = 1'b1;
    BusAddrData = 16'h0211;
    @(negedge clk);
    n_checks++;
    if (rdEn !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midrst_t4_idle: got rdEn=%b expected 0", rdEn);
    end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      AddrValid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (rdEn !== 1'b1 || Addr !== 8'h10 + 8'((1 + i) % 4) || BusDataOut !== a_data[(1 + i) % 4]) begin
        n_fail++;
        $display("[TB] FAIL midrst_reread beat %0d: got rdEn=%b Addr=%h Out=%h expected 1 %h %h", i, rdEn, Addr, BusDataOut, 8'h10 + 8'((1 + i) % 4), a_data[(1 + i) % 4]);
      end
    end
    next_cycle();
    rd_exp++;
    @(negedge clk);
    n_checks++;
    if (rdEn !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midrst_reread_end: got rdEn=%b expected 0", rdEn);
    end
`ifdef MEMCTRL_STATS_EN
    n_checks++;
    if (rdBursts !== 16'(rd_exp)) begin
      n_fail++;
      $display("[TB] FAIL midrst_stats: got rd=%0d expected %0d", rdBursts, rd_exp);
    end
`endif
  endtask

  task automatic test_back_to_back();
    next_cycle();
    AddrValid   = 1'b1;
    rw          = 1'b1;
    BusAddrData = 16'h0213;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 4; i++) begin
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (rdEn !== 1'b1 || Addr !== 8'h10 + 8'((3 + i) % 4) || BusDataOut !== a_data[(3 + i) % 4]) begin
          n_fail++;
          $display("[TB] FAIL b2b_beat burst %0d beat %0d: got rdEn=%b Addr=%h Out=%h expected 1 %h %h", b, i, rdEn, Addr, BusDataOut, 8'h10 + 8'((3 + i) % 4), a_data[(3 + i) % 4]);
        end
      end
      next_cycle();
      if (b == 1) AddrValid = 1'b0;
      rd_exp++;
      @(negedge clk);
      n_checks++;
      if ({rdEn, wrEn, BusDataOE} !== 3'b000) begin
        n_fail++;
        $display("[TB] FAIL b2b_gap burst %0d: got %b expected 000", b, {rdEn, wrEn, BusDataOE});
      end
`ifdef MEMCTRL_STATS_EN
      n_checks++;
      if (rdBursts !== 16'(rd_exp)) begin
        n_fail++;
        $display("[TB] FAIL b2b_stats burst %0d: got rd=%0d expected %0d", b, rdBursts, rd_exp);
      end
`endif
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({rdEn, wrEn, BusDataOE} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL b2b_final_idle: got %b expected 000", {rdEn, wrEn, BusDataOE});
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 16'h0000;
    a_data[0] = 16'hA000;
    a_data[1] = 16'hA111;
    a_data[2] = 16'hA222;
    a_data[3] = 16'hA333;
    resetL      = 1'b0;
    AddrValid   = 1'b0;
    rw          = 1'b0;
    BusAddrData = 16'h0000;

    test_reset();
    test_write();
    test_read();
    test_page_miss();
    test_reset_mid_burst();
    test_back_to_back();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
